// File: rtl/layer_seq_pkg.sv
// Shared state encoding and pipeline-controller timing constants for layer_sequencer.
package layer_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ACK   = 3'd2,
    S_RUN   = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  // Controller busy length per layer and start-to-busy latency.
  localparam int PIPE_LAYER_CYCLES = 8;
  localparam int PIPE_ACK_LAT      = 1;

  function automatic logic is_active(state_e s);
    return (s != S_IDLE) && (s != S_ERR);
  endfunction

endpackage

// File: rtl/layer_seq_if.sv
// Job handshake and pipeline-controller port bundle; slave side is the sequencer.
interface layer_seq_if #(parameter int LAYER_W = 4);
  logic               job_valid;
  logic               job_ready;
  logic [LAYER_W-1:0] job_layers;
  logic               pipe_start;
  logic               pipe_busy;
  logic [LAYER_W-1:0] layer_idx;
  logic               layer_last;
  logic               active;
  logic               done;
  logic               err;

  modport master (
    output job_valid, job_layers, pipe_busy,
    input  job_ready, pipe_start, layer_idx, layer_last, active, done, err
  );

  modport slave (
    input  job_valid, job_layers, pipe_busy,
    output job_ready, pipe_start, layer_idx, layer_last, active, done, err
  );
endinterface

// File: rtl/layer_seq_wdog.sv
// RUN-phase watchdog: counts busy cycles since RUN entry, flags when WDOG_CYCLES is reached.
module layer_seq_wdog #(
  parameter int WDOG_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_timeout
);
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WDOG_CYCLES);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr)
      r_cnt <= '0;
    else if (i_inc && r_cnt != LIMIT)
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_timeout = (r_cnt == LIMIT);
endmodule

// File: rtl/layer_sequencer.sv
// Job-level sequencer: one pipe_start per layer, tracks controller busy, pulses done.
// Optional watchdog (ACK check + RUN timeout) compiled in with LAYER_SEQ_WDOG_EN.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int LAYER_W     = 4,
  parameter int GAP_CYCLES  = 0,
  parameter int WDOG_CYCLES = 15
) (
  input  logic      clk,
  input  logic      rst_n,
  layer_seq_if.slave bus
);
  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  if (GAP_CYCLES < 0 || GAP_CYCLES > 15 || WDOG_CYCLES < 1) begin : g_bad_cfg
    $error("layer_sequencer: GAP_CYCLES or WDOG_CYCLES out of range");
  end

  state_e             r_state;
  logic [LAYER_W-1:0] r_layers;
  logic [LAYER_W-1:0] r_idx;
  logic [3:0]         r_gap;
  logic               w_last_idx;
  logic               w_timeout;

`ifdef LAYER_SEQ_WDOG_EN
  localparam bit WDOG_EN = 1'b1;

  layer_seq_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (r_state != S_RUN),
    .i_inc    (bus.pipe_busy),
    .o_timeout(w_timeout)
  );

  assign bus.err = (r_state == S_ERR);
`else
  localparam bit WDOG_EN = 1'b0;

  assign w_timeout = 1'b0;
  assign bus.err   = 1'b0;
`endif

  // For a zero-layer job r_layers-1 wraps to all-ones, which r_idx never reaches.
  assign w_last_idx = (r_idx == r_layers - 1'b1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_layers <= '0;
      r_idx    <= '0;
      r_gap    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.job_valid) begin
          r_layers <= bus.job_layers;
          r_idx    <= '0;
          r_state  <= (bus.job_layers == '0) ? S_DONE : S_START;
        end
        S_START: r_state <= S_ACK;
        S_ACK: begin
          if (bus.pipe_busy)  r_state <= S_RUN;
          else if (WDOG_EN)   r_state <= S_ERR;
        end
        S_RUN: begin
          if (w_timeout) begin
            r_state <= S_ERR;
          end else if (!bus.pipe_busy) begin
            if (w_last_idx) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_gap   <= GAP_LOAD;
              r_state <= (GAP_CYCLES == 0) ? S_START : S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap == '0) r_state <= S_START;
          else             r_gap   <= r_gap - 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode: every output is a function of registered state only.
  assign bus.job_ready  = (r_state == S_IDLE);
  assign bus.pipe_start = (r_state == S_START);
  assign bus.done       = (r_state == S_DONE);
  assign bus.active     = is_active(r_state);
  assign bus.layer_last = is_active(r_state) && w_last_idx;
  assign bus.layer_idx  = (r_state == S_ERR) ? '0 : r_idx;
endmodule

// File: tb/tb_layer_sequencer.sv
// Random + directed bench for layer_sequencer (GAP 0 and GAP 2 instances) against a timing-formula model.
module tb_layer_sequencer;
  import layer_seq_pkg::*;

  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stimulus and controller model for the two main instances (0: GAP=0, 1: GAP=2).
  logic          v   [2];
  logic [LW-1:0] lay [2];
  int            bcnt[2];

  layer_seq_if #(.LAYER_W(LW)) if0 ();
  layer_seq_if #(.LAYER_W(LW)) if1 ();

  assign if0.job_valid  = v[0];
  assign if0.job_layers = lay[0];
  assign if0.pipe_busy  = (bcnt[0] != 0);
  assign if1.job_valid  = v[1];
  assign if1.job_layers = lay[1];
  assign if1.pipe_busy  = (bcnt[1] != 0);

  layer_sequencer #(.LAYER_W(LW), .GAP_CYCLES(0), .WDOG_CYCLES(15)) u_g0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  layer_sequencer #(.LAYER_W(LW), .GAP_CYCLES(2), .WDOG_CYCLES(15)) u_g2 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  // Controller: busy one cycle after start, held PIPE_LAYER_CYCLES cycles.
  always @(posedge clk) begin
    if (!rst_n) begin
      bcnt[0] <= 0;
      bcnt[1] <= 0;
    end else begin
      if (if0.pipe_start)   bcnt[0] <= PIPE_LAYER_CYCLES;
      else if (bcnt[0] != 0) bcnt[0] <= bcnt[0] - 1;
      if (if1.pipe_start)   bcnt[1] <= PIPE_LAYER_CYCLES;
      else if (bcnt[1] != 0) bcnt[1] <= bcnt[1] - 1;
    end
  end

  // Reference model: per instance, the accepted job (accept cycle, layers, done cycle).
  bit            chk_en = 1'b0;
  bit            in_job  [2] = '{1'b0, 1'b0};
  int            ja      [2];
  int            jn      [2];
  int            jd      [2];
  logic [LW-1:0] last_idx[2] = '{'0, '0};

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Vector: {ready, active, pipe_start, done, layer_last, err, layer_idx}
  function automatic logic [9:0] model_vec(input int d, input int t);
    int g, p, rel, k;
    logic st, dn, ls;
    g = gap_of(d);
    p = 10 + g;
    if (!in_job[d]) return {6'b100000, last_idx[d]};
    rel = t - ja[d];
    k = (rel - 1 + g) / p;
    if (k > jn[d] - 1) k = jn[d] - 1;
    if (k < 0) k = 0;
    st = (jn[d] > 0) && (t < jd[d]) && (((rel - 1) % p) == 0);
    dn = (t == jd[d]);
    ls = (jn[d] > 0) && (k == jn[d] - 1);
    return {1'b0, 1'b1, st, dn, ls, 1'b0, 4'(k)};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("g0_outs", 32'({if0.job_ready, if0.active, if0.pipe_start, if0.done,
                          if0.layer_last, if0.err, if0.layer_idx}), 32'(model_vec(0, int'(cyc))));
      chk("g2_outs", 32'({if1.job_ready, if1.active, if1.pipe_start, if1.done,
                          if1.layer_last, if1.err, if1.layer_idx}), 32'(model_vec(1, int'(cyc))));
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          in_job[d]   = 1'b0;
          last_idx[d] = '0;
        end else if (in_job[d] && int'(cyc) == jd[d]) begin
          in_job[d]   = 1'b0;
          last_idx[d] = (jn[d] == 0) ? '0 : 4'(jn[d] - 1);
        end else if (!in_job[d] && v[d]) begin
          in_job[d] = 1'b1;
          ja[d]     = int'(cyc);
          jn[d]     = int'(lay[d]);
          jd[d]     = (jn[d] == 0) ? ja[d] + 1
                                   : ja[d] + 1 + jn[d] * (10 + gap_of(d)) - gap_of(d);
        end
      end
    end
  end

  task automatic offer(input int n);
    v[0] = 1'b1; v[1] = 1'b1;
    lay[0] = 4'(n); lay[1] = 4'(n);
    step(1);
    v[0] = 1'b0; v[1] = 1'b0;
  endtask

  initial begin
    lay[0] = '0; lay[1] = '0;
    v[0] = 1'b1; v[1] = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    step(2);
    rst_n = 1'b1;
    v[0] = 1'b0; v[1] = 1'b0;
    step(3);

    offer(3);  step(40);
    offer(0);  step(4);
    // Mid-job offers must be ignored.
    offer(2);  step(8);
    v[0] = 1'b1; v[1] = 1'b1; lay[0] = 4'd9; lay[1] = 4'd9;
    step(3);
    v[0] = 1'b0; v[1] = 1'b0;
    step(20);
    // Reset during layer 2 RUN, then a clean job.
    offer(5);  step(22);
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    step(2);
    offer(4);  step(50);
    offer(15); step(200);

    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        v[d]   = ($urandom_range(0, 7) == 0);
        lay[d] = 4'($urandom_range(0, 15));
      end
      rst_n = ($urandom_range(0, 599) != 0);
      step(1);
    end
    v[0] = 1'b0; v[1] = 1'b0; rst_n = 1'b1;
    step(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

`ifdef LAYER_SEQ_WDOG_EN
  logic          rst_w = 1'b0;
  logic          v_w = 1'b0;
  logic          busy_w = 1'b0;
  logic [LW-1:0] lay_w = 4'd1;

  layer_seq_if #(.LAYER_W(LW)) ifw ();
  assign ifw.job_valid  = v_w;
  assign ifw.job_layers = lay_w;
  assign ifw.pipe_busy  = busy_w;

  layer_sequencer #(.LAYER_W(LW), .GAP_CYCLES(0), .WDOG_CYCLES(15)) u_w (
    .clk(clk), .rst_n(rst_w), .bus(ifw)
  );

  initial begin
    step(3);
    rst_w = 1'b1;
    // Busy stuck high: RUN entry at A+3, err from A+19.
    v_w = 1'b1; step(1); v_w = 1'b0;
    busy_w = 1'b1;
    step(17);
    @(negedge clk); chk("wd_run_pre", 32'(ifw.err), 32'd0);
    @(negedge clk); chk("wd_run_err", 32'(ifw.err), 32'd1);
    chk("wd_err_outs", 32'({ifw.job_ready, ifw.active, ifw.pipe_start, ifw.done,
                            ifw.layer_last, ifw.layer_idx}), 32'd0);
    repeat (6) @(negedge clk);
    chk("wd_sticky", 32'(ifw.err), 32'd1);
    // Busy never raised: err one cycle after ACK.
    step(1);
    rst_w = 1'b0; busy_w = 1'b0; step(2);
    rst_w = 1'b1;
    chk("wd_rst_clr", 32'(ifw.err), 32'd0);
    v_w = 1'b1; step(1); v_w = 1'b0;
    @(negedge clk); chk("wd_ack_start", 32'(ifw.pipe_start), 32'd1);
    @(negedge clk); chk("wd_ack_pre", 32'(ifw.err), 32'd0);
    @(negedge clk); chk("wd_ack_err", 32'(ifw.err), 32'd1);
  end
`endif

endmodule
